// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - buffers one frame from the bridge, pads it and streams it to the MAC
module eth_tx_framer #(
    parameter int                DATA_W     = 8,
    parameter int                LEN_W      = 16,
    parameter int                BUF_DEPTH  = 256,
    parameter int                MIN_FRAME  = 64,
    parameter logic [DATA_W-1:0] PAD_BYTE   = 8'h00,
    parameter int                IFG_CYCLES = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LEN_W-1:0]  frm_len,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid,
    input  logic              tx_mac_ready,
    output logic              tx_last,
    output logic              busy,
    output logic              len_err,
    output logic [LEN_W-1:0]  frame_cnt
);
    localparam int                AW       = $clog2(BUF_DEPTH);
    localparam logic [LEN_W:0]    DEPTH_L  = (LEN_W+1)'(BUF_DEPTH);
    localparam logic [LEN_W-1:0]  MIN_L    = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0]  IFG_L    = LEN_W'(IFG_CYCLES);
    localparam logic [DATA_W-1:0] RST_DATA = DATA_W'(8'hd2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DROP,
        S_FILL,
        S_SEND,
        S_GAP
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   wr_cnt;
    logic [LEN_W-1:0]   rd_cnt;
    logic [LEN_W-1:0]   gap_cnt;
    logic [DATA_W-1:0]  mem [BUF_DEPTH];

    logic               in_hs;
    logic               len_ok;
    logic [LEN_W-1:0]   total;
    logic [LEN_W-1:0]   wr_next;
    logic [LEN_W-1:0]   rd_next;
    logic [LEN_W-1:0]   rd_sel;
    logic [DATA_W-1:0]  rd_byte;
    logic               buf_we;
    logic [AW-1:0]      buf_waddr;

    assign in_hs     = in_valid && in_ready;
    assign len_ok    = (frm_len != '0) && ({1'b0, frm_len} <= DEPTH_L);
    assign total     = (len_q > MIN_L) ? len_q : MIN_L;
    assign wr_next   = wr_cnt + 1'b1;
    assign rd_next   = rd_cnt + 1'b1;
    assign busy      = (state != S_IDLE);

    // While priming the first byte of SEND rd_cnt itself is fetched; afterwards
    // each handshake fetches the following index.
    assign rd_sel    = tx_valid ? rd_next : rd_cnt;
    assign rd_byte   = (rd_sel < len_q) ? mem[rd_sel[AW-1:0]] : PAD_BYTE;

    assign buf_we    = in_hs && (((state == S_IDLE) && len_ok) || (state == S_FILL));
    assign buf_waddr = (state == S_FILL) ? wr_cnt[AW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (buf_we) begin
            mem[buf_waddr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            gap_cnt   <= '0;
            in_ready  <= 1'b0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            tx_data_o <= RST_DATA;
            len_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            len_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        len_q  <= frm_len;
                        wr_cnt <= LEN_W'(1);
                        if (!len_ok) begin
                            len_err <= 1'b1;
                            // a zero length consumes only this byte
                            if (frm_len != '0) begin
                                state <= S_DROP;
                            end
                        end else if (frm_len == LEN_W'(1)) begin
                            state    <= S_SEND;
                            in_ready <= 1'b0;
                            rd_cnt   <= '0;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end
                S_DROP: begin
                    if (in_hs) begin
                        wr_cnt <= wr_next;
                        if (wr_next == len_q) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_FILL: begin
                    if (in_hs) begin
                        wr_cnt <= wr_next;
                        if (wr_next == len_q) begin
                            state    <= S_SEND;
                            in_ready <= 1'b0;
                            rd_cnt   <= '0;
                        end
                    end
                end
                S_SEND: begin
                    if (!tx_valid || tx_mac_ready) begin
                        if (tx_valid && tx_last) begin
                            tx_valid  <= 1'b0;
                            tx_last   <= 1'b0;
                            frame_cnt <= frame_cnt + 1'b1;
                            gap_cnt   <= '0;
                            if (IFG_CYCLES == 0) begin
                                state    <= S_IDLE;
                                in_ready <= 1'b1;
                            end else begin
                                state <= S_GAP;
                            end
                        end else begin
                            tx_valid  <= 1'b1;
                            tx_data_o <= rd_byte;
                            tx_last   <= (rd_sel == total - 1'b1);
                            rd_cnt    <= rd_sel;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == IFG_L - 1'b1) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - self-checking bench for eth_tx_framer
module tb_eth_tx_framer;
    localparam int BUF_DEPTH = 256;
    localparam int MIN_FRAME = 64;
    localparam int IFG       = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] frm_len = '0;
    logic [7:0]  tx_data_o;
    logic        tx_valid;
    logic        tx_mac_ready = 1'b1;
    logic        tx_last;
    logic        busy;
    logic        len_err;
    logic [15:0] frame_cnt;

    eth_tx_framer dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .frm_len      (frm_len),
        .tx_data_o    (tx_data_o),
        .tx_valid     (tx_valid),
        .tx_mac_ready (tx_mac_ready),
        .tx_last      (tx_last),
        .busy         (busy),
        .len_err      (len_err),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // MAC ready pattern: 0 = always, 1 = toggling, 2 = random
    int mac_mode = 0;
    always @(posedge clk) begin
        #1;
        case (mac_mode)
            0:       tx_mac_ready = 1'b1;
            1:       tx_mac_ready = ~tx_mac_ready;
            default: tx_mac_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    logic [7:0] got_data[$];
    bit         got_last[$];
    int  len_err_cycles = 0;
    int  valid_cycles = 0;
    int  stall_viol = 0;
    int  gap_seen = 0;
    bit  gap_done = 0;
    bit  pend = 0;
    int  last_hs_cyc = 0;
    int  first_valid_cyc = -1;
    bit  prev_v = 0;
    bit  prev_r = 0;
    bit  prev_l = 0;
    logic [7:0] prev_d = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 0;
            pend = 0;
        end else begin
            if (prev_v && !prev_r && (!tx_valid || tx_data_o != prev_d || tx_last != prev_l))
                stall_viol++;
            if (tx_valid && !prev_v && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (tx_valid && tx_mac_ready) begin
                got_data.push_back(tx_data_o);
                got_last.push_back(tx_last);
                if (tx_last) begin
                    last_hs_cyc = cyc;
                    pend = 1;
                end
            end else if (pend && in_ready) begin
                gap_seen = cyc - last_hs_cyc;
                pend = 0;
                gap_done = 1;
            end
            if (len_err) len_err_cycles++;
            if (tx_valid) valid_cycles++;
            prev_v = tx_valid;
            prev_r = tx_mac_ready;
            prev_d = tx_data_o;
            prev_l = tx_last;
        end
    end

    // Reference model: the frame is the payload, then PAD bytes up to MIN_FRAME.
    logic [7:0] payload[$];
    logic [7:0] exp_q[$];
    int exp_fc = 0;
    int last_in_cyc = 0;

    function automatic int model_len(input int len);
        if (len == 0 || len > BUF_DEPTH) return 0;
        return (len > MIN_FRAME) ? len : MIN_FRAME;
    endfunction

    task automatic build_exp(input int len);
        exp_q.delete();
        for (int i = 0; i < model_len(len); i++)
            exp_q.push_back((i < len) ? payload[i] : 8'h00);
    endtask

    task automatic drive_frame(input int len, input bit gaps, input string nm);
        int  n;
        int  i;
        int  budget;
        int  hs_cyc;
        bit  hs;
        n = (len == 0) ? 1 : len;
        payload.delete();
        for (int k = 0; k < n; k++) payload.push_back(8'($urandom));
        i = 0;
        budget = 0;
        while (i < n && budget < n * 8 + 300) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = payload[i];
                frm_len  = (i == 0) ? 16'(len) : 16'($urandom);
            end
            hs = in_valid && in_ready;
            hs_cyc = cyc;
            @(posedge clk); #1;
            budget++;
            if (hs) begin
                if (i == n - 1) last_in_cyc = hs_cyc;
                i++;
            end
        end
        in_valid = 1'b0;
        if (i < n) chk({nm, "_in_timeout"}, i, n);
    endtask

    task automatic run_frame(input int len, input bit gaps, input int exp_err,
                             input int exp_len, input string nm);
        int base_err;
        int base_valid;
        int b;
        int bad;
        int nlast;
        got_data.delete();
        got_last.delete();
        gap_done = 0;
        first_valid_cyc = -1;
        stall_viol = 0;
        base_err = len_err_cycles;
        base_valid = valid_cycles;
        drive_frame(len, gaps, nm);
        build_exp(len);
        if (exp_len > 0) begin
            b = 0;
            while (!gap_done && b < 5000) begin
                @(posedge clk); #1;
                b++;
            end
            chk({nm, "_done"}, int'(gap_done), 1);
            exp_fc++;
            chk({nm, "_len"}, got_data.size(), exp_len);
            bad = 0;
            for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
                if (got_data[i] !== exp_q[i]) bad++;
            chk({nm, "_data_bad"}, bad, 0);
            nlast = 0;
            foreach (got_last[i]) if (got_last[i]) nlast++;
            chk({nm, "_last_cnt"}, nlast, 1);
            if (got_last.size() > 0) chk({nm, "_last_pos"}, int'(got_last[got_last.size()-1]), 1);
            chk({nm, "_gap"}, gap_seen, IFG + 1);
            chk({nm, "_latency"}, first_valid_cyc - last_in_cyc, 2);
            chk({nm, "_stall"}, stall_viol, 0);
        end else begin
            repeat (8) begin @(posedge clk); #1; end
            chk({nm, "_no_tx"}, valid_cycles - base_valid, 0);
            chk({nm, "_in_ready"}, int'(in_ready), 1);
        end
        chk({nm, "_len_err"}, len_err_cycles - base_err, exp_err);
        chk({nm, "_frame_cnt"}, int'(frame_cnt), exp_fc);
    endtask

    typedef struct {
        string nm;
        int    len;
        int    mode;
        bit    gaps;
        int    exp_err;
        int    exp_len;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"l100",  100, 0, 0, 0, 100});
        vecs.push_back('{"l10",    10, 0, 0, 0,  64});
        vecs.push_back('{"l64tog", 64, 1, 0, 0,  64});
        vecs.push_back('{"l300",  300, 0, 0, 1,   0});
        vecs.push_back('{"l70",    70, 2, 1, 0,  70});
        vecs.push_back('{"l1",      1, 0, 0, 0,  64});
        vecs.push_back('{"l256",  256, 0, 0, 0, 256});
        vecs.push_back('{"l0",      0, 0, 0, 1,   0});
        vecs.push_back('{"l257",  257, 0, 1, 1,   0});
        vecs.push_back('{"l65",    65, 1, 1, 0,  65});
        vecs.push_back('{"l63",    63, 2, 0, 0,  64});

        #22;
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_last", int'(tx_last), 0);
        chk("rst_tx_data", int'(tx_data_o), 'hd2);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_len_err", int'(len_err), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (vecs[v]) begin
            mac_mode = vecs[v].mode;
            run_frame(vecs[v].len, vecs[v].gaps, vecs[v].exp_err, vecs[v].exp_len, vecs[v].nm);
        end

        begin : reset_mid_send
            int b;
            mac_mode = 0;
            got_data.delete();
            got_last.delete();
            drive_frame(64, 0, "abort");
            b = 0;
            while (got_data.size() < 30 && b < 500) begin
                @(posedge clk); #1;
                b++;
            end
            chk("abort_reached", int'(got_data.size() >= 30), 1);
            chk("abort_busy", int'(busy), 1);
            rst = 1'b0;
            #1;
            chk("abort_tx_valid", int'(tx_valid), 0);
            chk("abort_tx_last", int'(tx_last), 0);
            chk("abort_tx_data", int'(tx_data_o), 'hd2);
            chk("abort_in_ready", int'(in_ready), 0);
            chk("abort_busy_low", int'(busy), 0);
            chk("abort_frame_cnt", int'(frame_cnt), 0);
            exp_fc = 0;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b1;
            run_frame(64, 0, 0, 64, "after_rst");
        end

        for (int r = 0; r < 20; r++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 320))
                                              : int'($urandom_range(1, BUF_DEPTH));
            mac_mode = int'($urandom_range(0, 2));
            run_frame(len, 1'($urandom_range(0, 1)), (len > BUF_DEPTH) ? 1 : 0,
                      model_len(len), $sformatf("rnd%0d_l%0d", r, len));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
